// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a combinational 32-bit ALU: grants one op,
// holds its control fields steady for SETTLE_CYCLES, samples the result and returns it.
module alu_req_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [14:0] req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [14:0] req1_op,
  output logic        req1_ready,
  output logic [2:0]  alu_r1,
  output logic [3:0]  alu_r6,
  output logic [1:0]  alu_r2,
  output logic [1:0]  alu_r3,
  output logic [1:0]  alu_r4,
  output logic [1:0]  alu_r5,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_id,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a rising edge where reqN_valid && reqN_ready,
  // a response on a rising edge where rsp_valid && rsp_ready; valid never waits on ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        op_id;
  logic        grant0, grant1;
  logic        accept;
  logic        capture;
  logic [14:0] op_sel;

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so the readies read 0 for the whole reset window.
        if (rst_n) begin
          if (req0_valid && (!req1_valid || last_grant)) grant0 = 1'b1;
          else if (req1_valid)                           grant1 = 1'b1;
          if (req0_valid || req1_valid) state_nxt = HOLD;
        end
      end
      HOLD:    if (cnt <= 4'd1) state_nxt = RESP;
      RESP:    if (rsp_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = grant0 | grant1;
  assign capture    = (state == HOLD) && (cnt <= 4'd1);
  assign op_sel     = grant1 ? req1_op : req0_op;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      alu_r1     <= 3'd0;
      alu_r6     <= 4'd0;
      alu_r2     <= 2'd0;
      alu_r3     <= 2'd0;
      alu_r4     <= 2'd0;
      alu_r5     <= 2'd0;
      rsp_data   <= 32'd0;
      rsp_carry  <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        {alu_r1, alu_r6, alu_r2, alu_r3, alu_r4, alu_r5} <= op_sel;
        op_id      <= grant1;
        last_grant <= grant1;
        cnt        <= 4'(SETTLE_CYCLES);
      end else if (state == HOLD) begin
        cnt <= cnt - 4'd1;
      end
      // The ALU result is only looked at on the last settle cycle.
      if (capture) begin
        rsp_data  <= alu_out;
        rsp_carry <= alu_carry;
        rsp_id    <= op_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: one instance with SETTLE_CYCLES=2 and one with 1, each with
// its own directed + random stimulus, a reference model and a response scoreboard.
module tb_alu_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input int inst, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL [inst %0d] %s: got %0h, want %0h", inst, name, act, exp);
    end
  endtask

  // Stand-in ALU: r1 selects the operation, r6 and {r2..r5} are replicated into operands.
  function automatic logic [32:0] alu_model(input logic [14:0] op);
    logic [31:0] a, b;
    logic [32:0] r;
    a = {8{op[11:8]}};
    b = {4{op[7:0]}};
    case (op[14:12])
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {1'b0, a << op[1:0]};
      3'd6:    r = {1'b0, ~a};
      default: r = {1'b0, b};
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_inst
    localparam int S = (g == 0) ? 2 : 1;

    logic        rst_n, req0_valid, req1_valid, req0_ready, req1_ready;
    logic [14:0] req0_op, req1_op;
    logic [2:0]  alu_r1;
    logic [3:0]  alu_r6;
    logic [1:0]  alu_r2, alu_r3, alu_r4, alu_r5, dbg_state;
    logic [31:0] alu_out, rsp_data, noise;
    logic        alu_carry, rsp_valid, rsp_ready, rsp_carry, rsp_id, busy, noise_c;
    logic        done = 1'b0;
    logic [32:0] alu_res;
    logic [14:0] alu_fields;
    logic [52:0] outs_all;
    int          tcyc = 0;

    assign alu_fields = {alu_r1, alu_r6, alu_r2, alu_r3, alu_r4, alu_r5};
    assign alu_res    = alu_model(alu_fields) ^ {noise_c, noise};
    assign alu_out    = alu_res[31:0];
    assign alu_carry  = alu_res[32];
    assign outs_all   = {req0_ready, req1_ready, rsp_valid, rsp_carry, rsp_id, busy,
                         alu_fields, rsp_data};

    alu_req_arbiter #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_ready(req1_ready),
      .alu_r1(alu_r1), .alu_r6(alu_r6), .alu_r2(alu_r2), .alu_r3(alu_r3),
      .alu_r4(alu_r4), .alu_r5(alu_r5), .alu_out(alu_out), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_carry(rsp_carry), .rsp_id(rsp_id), .busy(busy), .dbg_state(dbg_state)
    );

    always @(posedge clk) tcyc <= tcyc + 1;

    // Reference model and scoreboard. Entry: {accept cycle[15:0], id, op[14:0]}.
    logic [31:0] exp_q[$];
    logic [32:0] noise_hist [0:8191];
    logic        m_busy = 1'b0, m_last = 1'b1, presented = 1'b0;
    logic        e0, e1, ev;
    int          m_acc = 0;
    logic [14:0] m_alu = '0;
    logic [33:0] m_rsp = '0;
    logic [31:0] ent;

    always @(negedge clk) begin
      if (!rst_n) begin
        m_busy = 1'b0; m_last = 1'b1; m_alu = '0; presented = 1'b0;
        exp_q.delete();
        chk(g, "outputs_in_reset", 64'(outs_all), 64'd0);
      end else begin
        noise_hist[13'(tcyc)] = {noise_c, noise};
        chk(g, "busy", 64'(busy), 64'(m_busy));
        chk(g, "alu_fields", 64'(alu_fields), 64'(m_alu));
        e0 = 1'b0;
        e1 = 1'b0;
        if (!m_busy) begin
          if (req0_valid && req1_valid) begin e0 = m_last; e1 = !m_last; end
          else begin e0 = req0_valid; e1 = req1_valid; end
        end
        chk(g, "req0_ready", 64'(req0_ready), 64'(e0));
        chk(g, "req1_ready", 64'(req1_ready), 64'(e1));
        ev = m_busy && (tcyc >= m_acc + S + 1);
        chk(g, "rsp_valid", 64'(rsp_valid), 64'(ev));
        if (rsp_valid && !presented) begin
          chk(g, "rsp_has_expect", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            ent   = exp_q.pop_front();
            m_rsp = {alu_model(ent[14:0]) ^ noise_hist[13'(int'(ent[31:16]) + S)], ent[15]};
          end
          presented = 1'b1;
        end
        if (rsp_valid) begin
          chk(g, "rsp_carry_data_id", 64'({rsp_carry, rsp_data, rsp_id}), 64'(m_rsp));
          if (rsp_ready) presented = 1'b0;
        end
        if (ev && rsp_ready) m_busy = 1'b0;
        if (e0 || e1) begin
          m_busy = 1'b1;
          m_acc  = tcyc;
          m_last = e1;
          m_alu  = e1 ? req1_op : req0_op;
          exp_q.push_back({16'(tcyc), e1, m_alu});
        end
      end
    end

    task automatic wait_accept(input int budget, output int id, output int at);
      id = -1;
      at = 0;
      for (int n = 0; n < budget; n++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          id = req1_ready ? 1 : 0;
          at = tcyc;
          break;
        end
      end
      chk(g, "accept_seen", 64'(id >= 0), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (busy && n < budget);
      chk(g, "idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic rand_step(input logic v0, input logic v1, input logic rr, input logic nz);
      @(posedge clk); #1;
      req0_valid = v0;
      req1_valid = v1;
      req0_op    = 15'($urandom);
      req1_op    = 15'($urandom);
      rsp_ready  = rr;
      noise      = nz ? $urandom : 32'd0;
      noise_c    = nz ? 1'($urandom) : 1'b0;
    endtask

    initial begin
      int id, at, prev, lat, hs;
      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; req0_op = '0; req1_op = '0;
      rsp_ready = 1'b0; noise = '0; noise_c = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;

      // Tie from reset: grants alternate starting with requester 0.
      @(posedge clk); #1;
      rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      req0_op = 15'($urandom); req1_op = 15'($urandom);
      prev = 0;
      for (int i = 0; i < 4; i++) begin
        wait_accept(40, id, at);
        chk(g, "tie_grant", 64'(id), 64'(i % 2));
        if (i > 0) chk(g, "tie_interval", 64'(at - prev), 64'(S + 2));
        prev = at;
        @(posedge clk); #1;
        if (id == 1) req1_op = 15'($urandom);
        else         req0_op = 15'($urandom);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle(40);

      // Single op with r6 = 0001.
      @(posedge clk); #1;
      req0_op = 15'h0100; req0_valid = 1'b1;
      wait_accept(10, id, at);
      chk(g, "single_id", 64'(id), 64'd0);
      @(posedge clk); #1 req0_valid = 1'b0;
      lat = -1;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (rsp_valid) begin lat = tcyc - at; break; end
      end
      chk(g, "single_latency", 64'(lat), 64'(S + 1));
      wait_idle(20);

      // Backpressure with both requesters waiting throughout.
      @(posedge clk); #1;
      rsp_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
      req0_op = 15'($urandom); req1_op = 15'($urandom);
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (rsp_valid) break;
      end
      repeat (5) @(negedge clk);
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk) hs = tcyc;
      wait_accept(5, id, at);
      chk(g, "bp_reaccept_gap", 64'(at - hs), 64'd1);
      @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle(20);

      // Op words and ALU result change every cycle; only the capture-cycle value counts.
      repeat (4 * (S + 2) + 3) rand_step(1'b1, 1'b0, 1'b1, 1'b1);
      rand_step(1'b0, 1'b0, 1'b1, 1'b0);
      wait_idle(20);

      // Reset in the first HOLD cycle.
      @(posedge clk); #1;
      req0_op = 15'($urandom); req0_valid = 1'b1;
      wait_accept(10, id, at);
      @(posedge clk); #2;
      rst_n = 1'b0; req1_valid = 1'b1;
      #1 chk(g, "reset_async_outputs", 64'(outs_all), 64'd0);
      repeat (2) @(posedge clk);
      #3 req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
      for (int n = 0; n < S + 5; n++) begin
        @(negedge clk);
        chk(g, "no_rsp_after_reset", 64'(rsp_valid), 64'd0);
      end
      @(posedge clk); #1 req1_op = 15'($urandom); req1_valid = 1'b1;
      wait_accept(10, id, at);
      @(posedge clk); #1 req1_valid = 1'b0;
      wait_idle(20);

      // Back-to-back from requester 1 alone.
      @(posedge clk); #1 req1_valid = 1'b1; req1_op = 15'($urandom);
      prev = 0;
      for (int i = 0; i < 4; i++) begin
        wait_accept(20, id, at);
        chk(g, "b2b_grant", 64'(id), 64'd1);
        if (i > 0) chk(g, "b2b_interval", 64'(at - prev), 64'(S + 2));
        prev = at;
      end
      @(posedge clk); #1 req1_valid = 1'b0;
      wait_idle(20);

      // Random traffic, random backpressure, noisy ALU.
      repeat (200) rand_step(1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));
      rand_step(1'b0, 1'b0, 1'b1, 1'b0);
      wait_idle(40);
      done = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(gen_inst[0].done && gen_inst[1].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk(0, "all_scenarios_done", 64'(gen_inst[0].done && gen_inst[1].done), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles the ALU control fields are held stable before the result is sampled (legal 1..15).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has an operation.
REQ-005 SHALL have port req0_op  input  15  requester 0 op word: [14:12]=r1, [11:8]=r6, [7:6]=r2, [5:4]=r3, [3:2]=r4, [1:0]=r5.
REQ-006 SHALL have port req0_ready  output  1  requester 0 op accepted this cycle when valid also high.
REQ-007 SHALL have ports req1_valid/req1_op/req1_ready with identical widths and meaning for requester 1.
REQ-008 SHALL have ports alu_r1 output 3, alu_r6 output 4, alu_r2..alu_r5 output 2 each: control fields driven to the 32-bit ALU.
REQ-009 SHALL have ports alu_out input 32 and alu_carry input 1: combinational ALU result.
REQ-010 SHALL have port rsp_valid  output  1  result available.
REQ-011 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-012 SHALL have ports rsp_data output 32, rsp_carry output 1, rsp_id output 1 (requester index that issued the op).
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, HOLD, RESP.
REQ-015 IDLE: if any reqN_valid, SHALL grant exactly one requester, assert its reqN_ready combinationally in that cycle, latch its op and index, load settle counter with SETTLE_CYCLES, go HOLD next edge.
REQ-016 reqN_ready SHALL be low in HOLD and RESP; never both readies high together.
REQ-017 Arbitration SHALL be round-robin: when both valid, grant the requester not granted last; when one valid, grant it regardless of history; last-grant pointer updates only on acceptance.
REQ-018 After reset the last-grant pointer SHALL equal 1, so requester 0 wins the first tie.
REQ-019 alu_* outputs SHALL be registered from the latched op, change only on acceptance, and hold their value in all other cycles (including IDLE after completion).
REQ-020 HOLD: counter SHALL decrement each cycle; on the cycle it equals 1, alu_out/alu_carry SHALL be captured into rsp_data/rsp_carry and FSM goes RESP; HOLD lasts exactly SETTLE_CYCLES cycles.
REQ-021 RESP: rsp_valid SHALL be high; rsp_data, rsp_carry, rsp_id stable until rsp_valid && rsp_ready, then FSM goes IDLE.
REQ-022 New request SHALL NOT be accepted in the cycle of response handshake; earliest next acceptance is the following IDLE cycle.
REQ-023 Latency: acceptance edge to rsp_valid high SHALL be SETTLE_CYCLES+1 cycles; minimum issue interval SETTLE_CYCLES+2 cycles.
REQ-024 Changes on req*_op or alu_out outside the capture cycle SHALL have no effect on outputs.
REQ-025 rsp_valid SHALL never drop without handshake; rsp_ready while not RESP SHALL be ignored.

Reset
REQ-026 While rst_n low, SHALL force state IDLE, counter 0, last-grant 1, and all outputs 0 (alu_* = 0, rsp_* = 0, busy 0, readies 0), immediately without a clock edge.
REQ-027 Reset asserted in HOLD or RESP SHALL abandon the op; no response emitted after reset release.
REQ-028 First acceptance SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-029 Single op: req0_valid with op {r1=000,r6=0001,r2..r5=00}, SETTLE_CYCLES=2 -> req0_ready same cycle, alu_r6=0001 next cycle, rsp_valid 3 cycles after acceptance, rsp_id=0, rsp_data equals model ALU output.
REQ-030 Tie: both valid continuously for 4 ops, rsp_ready tied high -> grants 0,1,0,1; each op issued SETTLE_CYCLES+2 cycles apart.
REQ-031 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid/data/carry/id unchanged, both readies low, alu_* unchanged; release -> IDLE next cycle.
REQ-032 Op stability: toggle req0_op and alu_out every cycle during HOLD -> alu_* hold accepted op, rsp_data equals alu_out at capture cycle only.
REQ-033 Reset mid-op: rst_n low in HOLD cycle 1 -> all outputs 0 asynchronously; after release no rsp_valid until a new request completes.
REQ-034 Boundary SETTLE_CYCLES=1: acceptance to rsp_valid = 2 cycles; single-requester back-to-back ops from req1 all granted to 1.
